// File: rtl/seg_pkg.sv
// Shared types and segment encodings for the 7-segment readback monitor.
// Segment bit order is a..g on bits 6..0, active-high, matching the display decoder.
package seg_pkg;

    typedef logic [6:0] seg_t;
    typedef logic [3:0] bcd_t;

    localparam seg_t SEG_0     = 7'b1111110;
    localparam seg_t SEG_1     = 7'b0110000;
    localparam seg_t SEG_2     = 7'b1101101;
    localparam seg_t SEG_3     = 7'b1111001;
    localparam seg_t SEG_4     = 7'b0110011;
    localparam seg_t SEG_5     = 7'b1011011;
    localparam seg_t SEG_6     = 7'b1011111;
    localparam seg_t SEG_7     = 7'b1110000;
    localparam seg_t SEG_8     = 7'b1111111;
    localparam seg_t SEG_9     = 7'b1111011;
    localparam seg_t SEG_BLANK = 7'b0000000;

    localparam bcd_t CODE_BLANK   = 4'hF;
    localparam bcd_t CODE_ILLEGAL = 4'hE;

endpackage

// File: rtl/seg_bcd_lut.sv
// Combinational segment-pattern to BCD decode; blank maps to CODE_BLANK,
// anything unrecognised maps to CODE_ILLEGAL with the illegal flag set.
module seg_bcd_lut
    import seg_pkg::*;
(
    input  seg_t seg_i,
    output bcd_t code_c,
    output logic illegal_c
);

    always_comb begin
        code_c = CODE_ILLEGAL;
        unique case (seg_i)
            SEG_0:     code_c = 4'd0;
            SEG_1:     code_c = 4'd1;
            SEG_2:     code_c = 4'd2;
            SEG_3:     code_c = 4'd3;
            SEG_4:     code_c = 4'd4;
            SEG_5:     code_c = 4'd5;
            SEG_6:     code_c = 4'd6;
            SEG_7:     code_c = 4'd7;
            SEG_8:     code_c = 4'd8;
            SEG_9:     code_c = 4'd9;
            SEG_BLANK: code_c = CODE_BLANK;
            default:   code_c = CODE_ILLEGAL;
        endcase
        illegal_c = (code_c == CODE_ILLEGAL);
    end

endmodule

// File: rtl/seg_bcd.sv
// Scanned 7-segment bus monitor: recovers and debounces the BCD code shown
// on each multiplexed position, committing a digit once its pattern is stable.
module seg_bcd
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned STABLE_CYCLES = 3
) (
    input  logic                    seg_bcd_clk,
    input  logic                    seg_bcd_rst_n,
    input  logic [6:0]              seg_bcd_seg_in,
    input  logic [NUM_DIGITS-1:0]   seg_bcd_sel_in,
    output logic [4*NUM_DIGITS-1:0] seg_bcd_digits_out,
    output logic [NUM_DIGITS-1:0]   seg_bcd_valid_out,
    output logic [NUM_DIGITS-1:0]   seg_bcd_illegal_out,
    output logic                    seg_bcd_changed_out,
    output logic                    seg_bcd_sel_err_out
);

    localparam int unsigned     CNT_W    = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    bcd_t [NUM_DIGITS-1:0]            digits_q,  digits_d;
    logic [NUM_DIGITS-1:0]            valid_q,   valid_d;
    logic [NUM_DIGITS-1:0]            illegal_q, illegal_d;
    logic                             changed_q, changed_d;
    logic                             sel_err_q, sel_err_d;
    seg_t [NUM_DIGITS-1:0]            cand_q,    cand_d;
    logic [NUM_DIGITS-1:0][CNT_W-1:0] cnt_q,     cnt_d;

    bcd_t lut_code;
    logic lut_illegal;
    logic sel_multi;
    logic sel_one;
    logic commit;

    // One decoder suffices: at most one position is sampled per clock.
    seg_bcd_lut u_lut (
        .seg_i     (seg_bcd_seg_in),
        .code_c    (lut_code),
        .illegal_c (lut_illegal)
    );

    always_ff @(posedge seg_bcd_clk) begin
        if (!seg_bcd_rst_n) begin
            digits_q  <= {NUM_DIGITS{CODE_BLANK}};
            valid_q   <= '0;
            illegal_q <= '0;
            changed_q <= 1'b0;
            sel_err_q <= 1'b0;
            cand_q    <= '0;
            cnt_q     <= '0;
        end else begin
            digits_q  <= digits_d;
            valid_q   <= valid_d;
            illegal_q <= illegal_d;
            changed_q <= changed_d;
            sel_err_q <= sel_err_d;
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        digits_d  = digits_q;
        valid_d   = valid_q;
        illegal_d = illegal_q;
        changed_d = 1'b0;
        cand_d    = cand_q;
        cnt_d     = cnt_q;
        commit    = 1'b0;

        // x & (x-1) clears the lowest set bit; non-zero result means multi-hot.
        sel_multi = (seg_bcd_sel_in & (seg_bcd_sel_in - NUM_DIGITS'(1))) != '0;
        sel_one   = (seg_bcd_sel_in != '0) && !sel_multi;
        sel_err_d = sel_multi;

        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (sel_one && seg_bcd_sel_in[i]) begin
                if (seg_bcd_seg_in != cand_q[i]) begin
                    cand_d[i] = seg_bcd_seg_in;
                    cnt_d[i]  = CNT_W'(1);
                    commit    = (STABLE_CYCLES == 1);
                end else if (cnt_q[i] < CNT_MAX) begin
                    cnt_d[i]  = cnt_q[i] + CNT_W'(1);
                    commit    = (cnt_q[i] == CNT_LAST);
                end
                if (commit) begin
                    digits_d[i]  = lut_code;
                    valid_d[i]   = 1'b1;
                    illegal_d[i] = lut_illegal;
                    changed_d    = !valid_q[i] || (lut_code != digits_q[i]);
                end
            end
        end
    end

    assign seg_bcd_digits_out  = digits_q;
    assign seg_bcd_valid_out   = valid_q;
    assign seg_bcd_illegal_out = illegal_q;
    assign seg_bcd_changed_out = changed_q;
    assign seg_bcd_sel_err_out = sel_err_q;

endmodule

// File: tb/tb_seg_bcd.sv
// Bench for seg_bcd: directed scenarios plus randomized scan traffic, checked
// against a run-length reference model of the debounce/commit rules.
module tb_seg_bcd;

    localparam int ND = 4;
    localparam int SC = 3;

    localparam logic [6:0] P1 = 7'b0110000;
    localparam logic [6:0] P2 = 7'b1101101;
    localparam logic [6:0] P3 = 7'b1111001;
    localparam logic [6:0] P5 = 7'b1011011;
    localparam logic [6:0] P7 = 7'b1110000;
    localparam logic [6:0] P8 = 7'b1111111;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  seg;
    logic [3:0]  sel;
    logic [15:0] digits;
    logic [3:0]  valid;
    logic [3:0]  illegal;
    logic        changed;
    logic        sel_err;

    int checks = 0;
    int errors = 0;

    logic [6:0] ref_pat [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                 7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                 7'b1111111, 7'b1111011};

    logic [15:0] exp_digits;
    logic [3:0]  exp_valid, exp_illegal;
    logic        exp_changed, exp_sel_err;
    logic [6:0]  m_last [ND];
    int          m_run  [ND];

    always #5 clk = ~clk;

    seg_bcd #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
        .seg_bcd_clk         (clk),
        .seg_bcd_rst_n       (rst_n),
        .seg_bcd_seg_in      (seg),
        .seg_bcd_sel_in      (sel),
        .seg_bcd_digits_out  (digits),
        .seg_bcd_valid_out   (valid),
        .seg_bcd_illegal_out (illegal),
        .seg_bcd_changed_out (changed),
        .seg_bcd_sel_err_out (sel_err)
    );

    wire [25:0] dut_vec = {digits, valid, illegal, changed, sel_err};

    function automatic logic [3:0] ref_decode(input logic [6:0] p);
        for (int k = 0; k < 10; k++)
            if (ref_pat[k] == p) return 4'(k);
        return (p == 7'b0) ? 4'hF : 4'hE;
    endfunction

    function automatic logic [25:0] exp_vec();
        return {exp_digits, exp_valid, exp_illegal, exp_changed, exp_sel_err};
    endfunction

    // Model: a digit commits when its current pattern has been seen exactly SC times in a row.
    task automatic model_step(input logic r, input logic [3:0] s, input logic [6:0] p);
        int d;
        logic [3:0] code;
        exp_changed = 1'b0;
        exp_sel_err = 1'b0;
        if (!r) begin
            exp_digits = 16'hFFFF; exp_valid = '0; exp_illegal = '0;
            for (int k = 0; k < ND; k++) begin m_last[k] = 7'b0; m_run[k] = 0; end
        end else if ($countones(s) > 1) begin
            exp_sel_err = 1'b1;
        end else if ($countones(s) == 1) begin
            d = 0;
            for (int k = 0; k < ND; k++) if (s[k]) d = k;
            if (p == m_last[d]) m_run[d] = m_run[d] + 1;
            else begin m_last[d] = p; m_run[d] = 1; end
            if (m_run[d] == SC) begin
                code = ref_decode(p);
                exp_changed = !exp_valid[d] || (exp_digits[4*d +: 4] != code);
                exp_digits[4*d +: 4] = code;
                exp_valid[d] = 1'b1;
                exp_illegal[d] = (code == 4'hE);
            end
        end
    endtask

    task automatic drive(input logic r, input logic [3:0] s, input logic [6:0] p);
        rst_n = r; sel = s; seg = p;
        @(posedge clk);
        model_step(r, s, p);
        #1;
    endtask

    task automatic test_reset();
        drive(1'b0, 4'b0000, 7'b0);
        checks++;
        if (digits !== 16'hFFFF) begin errors++; $display("FAIL reset_digits got %h exp ffff", digits); end
        checks++;
        if ({valid, illegal, changed, sel_err} !== 10'b0) begin
            errors++; $display("FAIL reset_flags got %b exp 0", {valid, illegal, changed, sel_err});
        end
    endtask

    task automatic test_commit();
        for (int n = 1; n <= SC; n++) begin
            drive(1'b1, 4'b0001, P3);
            checks++;
            if (dut_vec !== exp_vec()) begin errors++; $display("FAIL commit_state n=%0d got %h exp %h", n, dut_vec, exp_vec()); end
        end
        checks++;
        if (digits[3:0] !== 4'd3 || valid[0] !== 1'b1 || changed !== 1'b1) begin
            errors++; $display("FAIL commit_digit0 got d=%h v=%b c=%b exp d=3 v=1 c=1", digits[3:0], valid[0], changed);
        end
        drive(1'b1, 4'b0000, P3);
        checks++;
        if (changed !== 1'b0) begin errors++; $display("FAIL commit_pulse_width got %b exp 0", changed); end
    endtask

    task automatic test_glitch();
        logic [6:0] seq [6] = '{P1, P1, P2, P1, P1, P1};
        for (int n = 0; n < 6; n++) begin
            drive(1'b1, 4'b0010, seq[n]);
            checks++;
            if (dut_vec !== exp_vec()) begin errors++; $display("FAIL glitch_state n=%0d got %h exp %h", n, dut_vec, exp_vec()); end
            checks++;
            if (digits[7:4] !== (n == 5 ? 4'd1 : 4'hF)) begin
                errors++; $display("FAIL glitch_digit1 n=%0d got %h", n, digits[7:4]);
            end
        end
    endtask

    task automatic test_illegal_blank();
        for (int n = 0; n < SC; n++) drive(1'b1, 4'b0100, 7'b1000000);
        checks++;
        if (digits[11:8] !== 4'hE || illegal[2] !== 1'b1) begin
            errors++; $display("FAIL illegal_commit got d=%h i=%b exp d=e i=1", digits[11:8], illegal[2]);
        end
        for (int n = 0; n < SC; n++) drive(1'b1, 4'b0100, 7'b0000000);
        checks++;
        if (digits[11:8] !== 4'hF || illegal[2] !== 1'b0 || valid[2] !== 1'b1) begin
            errors++; $display("FAIL blank_commit got d=%h i=%b v=%b exp d=f i=0 v=1", digits[11:8], illegal[2], valid[2]);
        end
        checks++;
        if (dut_vec !== exp_vec()) begin errors++; $display("FAIL blank_state got %h exp %h", dut_vec, exp_vec()); end
    endtask

    task automatic test_sel_err();
        drive(1'b1, 4'b1000, P5);
        drive(1'b1, 4'b0011, P5);
        checks++;
        if (sel_err !== 1'b1) begin errors++; $display("FAIL sel_err_pulse got %b exp 1", sel_err); end
        drive(1'b1, 4'b0000, P5);
        checks++;
        if (sel_err !== 1'b0 || dut_vec !== exp_vec()) begin
            errors++; $display("FAIL sel_zero got %h exp %h", dut_vec, exp_vec());
        end
        drive(1'b1, 4'b1000, P5);
        drive(1'b1, 4'b1000, P5);
        checks++;
        if (digits[15:12] !== 4'd5 || changed !== 1'b1) begin
            errors++; $display("FAIL sel_no_disturb got d=%h c=%b exp d=5 c=1", digits[15:12], changed);
        end
    endtask

    task automatic test_recommit_reset();
        drive(1'b1, 4'b0001, P8);
        for (int n = 0; n < SC; n++) begin
            drive(1'b1, 4'b0001, P3);
            checks++;
            if (changed !== 1'b0 || digits[3:0] !== 4'd3) begin
                errors++; $display("FAIL recommit n=%0d got d=%h c=%b exp d=3 c=0", n, digits[3:0], changed);
            end
        end
        drive(1'b1, 4'b0001, P8);
        drive(1'b1, 4'b1000, P7);
        drive(1'b1, 4'b1000, P7);
        drive(1'b0, 4'b1000, P7);
        drive(1'b1, 4'b1000, P7);
        drive(1'b1, 4'b1000, P7);
        checks++;
        if (digits[15:12] !== 4'hF || valid[3] !== 1'b0) begin
            errors++; $display("FAIL reset_midstream got d=%h v=%b exp d=f v=0", digits[15:12], valid[3]);
        end
        drive(1'b1, 4'b1000, P7);
        checks++;
        if (digits[15:12] !== 4'd7 || valid[3] !== 1'b1 || changed !== 1'b1) begin
            errors++; $display("FAIL reset_recommit got d=%h v=%b c=%b exp d=7 v=1 c=1", digits[15:12], valid[3], changed);
        end
    endtask

    task automatic test_random();
        logic [3:0] s;
        logic [6:0] p;
        int kind, len, i, j;
        drive(1'b0, 4'b0000, 7'b0);
        for (int it = 0; it < 300; it++) begin
            kind = int'($urandom_range(0, 11));
            p = (kind < 10) ? ref_pat[kind] : (kind == 10) ? 7'b0 : 7'($urandom);
            i = int'($urandom_range(0, 3));
            kind = int'($urandom_range(0, 9));
            if (kind == 0) s = 4'b0000;
            else if (kind == 1) begin
                j = (i + int'($urandom_range(1, 3))) % 4;
                s = 4'(1 << i) | 4'(1 << j);
            end else s = 4'(1 << i);
            len = int'($urandom_range(1, 5));
            for (int n = 0; n < len; n++) begin
                drive(($urandom_range(0, 99) != 0), s, p);
                checks++;
                if (dut_vec !== exp_vec()) begin
                    errors++; $display("FAIL random it=%0d got %h exp %h", it, dut_vec, exp_vec());
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; sel = '0; seg = '0;
        test_reset();
        test_commit();
        test_glitch();
        test_illegal_blank();
        test_sel_err();
        test_recommit_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_bcd.md
Name: seg_bcd

Overview:
- Inverse of the team's BCD-to-7-segment decoder: watches a scanned, multiplexed 7-segment display bus and recovers the BCD digit shown on each position.
- Sits beside the clock display driver. Used as a self-check/readback monitor and as a scoreboard front-end in the display testbenches.
- Debounces each digit: a value is committed only after its segment pattern has been held stable for a programmable number of scan samples.

Parameters:
- NUM_DIGITS, 4, number of multiplexed display positions (HH:MM).
- STABLE_CYCLES, 3, consecutive identical samples of one digit needed to commit it; legal range is 1 or more.

Ports:
- seg_bcd_clk  input  1  single clock; all state updates on its rising edge.
- seg_bcd_rst_n  input  1  synchronous, active-low reset.
- seg_bcd_seg_in  input  7  segment pattern, active-high, bit6=a … bit0=g (e.g. 7'b1111110 = "0").
- seg_bcd_sel_in  input  NUM_DIGITS  one-hot digit enable, active-high; bit d selects position d.
- seg_bcd_digits_out  output  4*NUM_DIGITS  committed code per digit; digit d is at [4d+3:4d].
- seg_bcd_valid_out  output  NUM_DIGITS  digit d has been committed at least once since reset.
- seg_bcd_illegal_out  output  NUM_DIGITS  last committed pattern of digit d was illegal.
- seg_bcd_changed_out  output  1  one-cycle pulse when any commit changes a digit code.
- seg_bcd_sel_err_out  output  1  one-cycle pulse when seg_bcd_sel_in is multi-hot.

Behaviour:
- Reset, checked on the clock edge while seg_bcd_rst_n=0:
  - all digit codes = 4'hF; valid, illegal, changed and sel_err = 0.
  - per-digit candidate pattern = 7'b0; per-digit counter = 0.
  - Applies mid-operation too: a partially stable digit needs a full STABLE_CYCLES again after reset is released.
- Pattern decode (combinational, in the sub-module):
  - legal patterns 0-9 → codes 0-9;
  - 7'b0000000 (blank) → 4'hF, not illegal;
  - any other pattern → 4'hE, illegal.
- Sample rules, per clock:
  - If seg_bcd_sel_in is zero: no state change.
  - If it has 2 or more bits set: no state change, and seg_bcd_sel_err_out=1 on the next cycle.
  - If exactly one bit d is set: position d is sampled with pattern p.
- Per-digit tracker, for a sampled digit d:
  - If p != cand[d]: cand[d] <= p, cnt[d] <= 1.
  - If p == cand[d] and cnt[d] < STABLE_CYCLES: cnt[d] <= cnt[d]+1.
  - At saturation the counter holds.
  - Commit happens on the sample that makes the new cnt equal STABLE_CYCLES. For STABLE_CYCLES=1, every new pattern commits immediately.
  - Further identical samples after saturation do not re-commit.
- Commit of digit d, registered and visible the cycle after the committing sample:
  - digit code <= decode(p); valid[d] <= 1; illegal[d] <= (code == 4'hE).
  - seg_bcd_changed_out=1 for one cycle if the new code differs from the previous code, or if valid[d] was 0.
- Unsampled digits keep their outputs and tracker state indefinitely. There is no timeout.
- Counter width is $clog2(STABLE_CYCLES+1) and saturating; no wrap-around.
- Latency: first commit is visible STABLE_CYCLES samples + 1 clock after the first sample of a new pattern.
- Only one digit can commit per cycle, so there is no commit collision.

Decomposition:
- Package seg_pkg:
  - pattern constants SEG_0..SEG_9 and SEG_BLANK, using the same encoding as the display decoder;
  - CODE_BLANK=4'hF, CODE_ILLEGAL=4'hE;
  - typedef seg_t (logic[6:0]) and bcd_t (logic[3:0]).
- One sub-module, seg_bcd_lut: purely combinational seg_t → bcd_t plus an illegal flag. It is instantiated once on seg_bcd_seg_in, because only one digit is sampled per cycle.

Test Plan:
- Reset: hold rst_n=0 for 1 edge → digits=16'hFFFF, valid=4'b0000, illegal=0, changed=0, sel_err=0.
- Commit: sel=4'b0001, seg=7'b1111001 for 3 cycles → next cycle digits[3:0]=3, valid[0]=1, changed pulses exactly 1 cycle.
- Glitch reject: sel=4'b0010; 7'b0110000 ×2, then 7'b1101101 ×1, then 7'b0110000 ×3 → digits[7:4] becomes 1 only after the final third sample; 2 is never committed.
- Illegal/blank:
  - sel=4'b0100, seg=7'b1000000 ×3 → digits[11:8]=E, illegal[2]=1;
  - then seg=7'b0000000 ×3 → digits[11:8]=F, illegal[2]=0.
- Select errors: sel=4'b0011 with any seg → sel_err pulse, no tracker change; sel=4'b0000 → no pulse, no change.
- Recommit and reset:
  - re-present the same "3" on digit 0 for 3 samples → no changed pulse;
  - drive "7" twice on digit 3, assert rst_n=0, release, drive "7" twice → still uncommitted; third sample commits.
